// File: rtl/tribus_arbiter_if.sv
// Bus-ownership interface between the tri-state arbiter and its requesters.
//   req      : per-requester bus request, level-held (requesters -> arbiter)
//   grant    : one-hot registered grant, all zero when the bus is not owned
//   en_n     : active-low buffer enables, always ~grant (1 = driver high-Z)
//   owner    : index of the current or most recent owner
//   bus_busy : high while a grant is active or a turnaround is in progress
// Modports: master = arbiter side, slave = requester side.
interface tribus_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();
  localparam int unsigned OW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] en_n;
  logic [OW-1:0]    owner;
  logic             bus_busy;

  modport master (
    input  req,
    output grant,
    output en_n,
    output owner,
    output bus_busy
  );

  modport slave (
    output req,
    input  grant,
    input  en_n,
    input  owner,
    input  bus_busy
  );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter sharing one tri-state bus between N_REQ bufif0 drivers.
// At most one driver is enabled at a time, every hand-over passes through
// TURNAROUND dead cycles with all drivers high-Z, and a tenure is cut after
// MAX_HOLD cycles when another requester is waiting.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   arb : tribus_arbiter_if.master (req in; grant, en_n, owner, bus_busy out)
module tribus_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input logic               clk,
  input logic               rst,
  tribus_arbiter_if.master  arb
);
  localparam int unsigned OW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = 8;
  localparam int unsigned TW = 2;

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e           r_state, w_state_d;
  logic [N_REQ-1:0] r_grant, w_grant_d;
  logic [N_REQ-1:0] r_en_n;
  logic [OW-1:0]    r_owner, w_owner_d;
  logic [OW-1:0]    r_last, w_last_d;
  logic [HW-1:0]    r_hold, w_hold_d;
  logic [TW-1:0]    r_turn, w_turn_d;
  logic             r_busy;

  logic             w_pick_valid;
  logic [OW-1:0]    w_pick;
  logic [OW-1:0]    w_sel;
  int unsigned      w_idx;
  logic             w_owner_req;
  logic             w_others;

  // Round-robin pick: first set req scanning upward from last+1, wrapping.
  // The previous owner is scanned last, so a forced-out owner only wins
  // again when nobody else is asking.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    w_idx        = 0;
    w_sel        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = 32'(r_last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_sel = OW'(w_idx);
      if (!w_pick_valid && arb.req[w_sel]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_sel;
      end
    end
  end

  // In StGrant r_grant is the one-hot owner mask.
  assign w_owner_req = |(arb.req & r_grant);
  assign w_others    = |(arb.req & ~r_grant);

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_owner_d = r_owner;
    w_last_d  = r_last;
    w_hold_d  = r_hold;
    w_turn_d  = r_turn;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_state_d = StGrant;
          w_grant_d = N_REQ'(1) << w_pick;
          w_owner_d = w_pick;
          w_last_d  = w_pick;
          w_hold_d  = '0;
        end
      end
      StGrant: begin
        if (!w_owner_req || (r_hold == HW'(MAX_HOLD - 1) && w_others)) begin
          w_state_d = StTurn;
          w_grant_d = '0;
          w_turn_d  = '0;
        end else if (r_hold != HW'(MAX_HOLD - 1)) begin
          w_hold_d = r_hold + HW'(1);
        end
      end
      StTurn: begin
        if (r_turn == TW'(TURNAROUND - 1)) begin
          if (w_pick_valid) begin
            w_state_d = StGrant;
            w_grant_d = N_REQ'(1) << w_pick;
            w_owner_d = w_pick;
            w_last_d  = w_pick;
            w_hold_d  = '0;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_turn_d = r_turn + TW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
    endcase
  end

  // Enables are registered from the same next-state as grant so en_n never
  // glitches and is always the exact complement of grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_en_n  <= '1;
      r_owner <= '0;
      r_last  <= OW'(N_REQ - 1);
      r_hold  <= '0;
      r_turn  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_en_n  <= ~w_grant_d;
      r_owner <= w_owner_d;
      r_last  <= w_last_d;
      r_hold  <= w_hold_d;
      r_turn  <= w_turn_d;
      r_busy  <= (w_state_d != StIdle);
    end
  end

  assign arb.grant    = r_grant;
  assign arb.en_n     = r_en_n;
  assign arb.owner    = r_owner;
  assign arb.bus_busy = r_busy;
endmodule

// File: tb/tb_tribus_arbiter.sv
// Self-checking bench for tribus_arbiter. Directed scenarios push expected
// bus segments (grant, bus_busy, length) into a queue; a monitor pops one
// whenever the DUT's {grant, bus_busy} changes. A second instance with
// TURNAROUND=2 drives real bufif0 drivers under random requests.
module tb_tribus_arbiter;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic [3:0]  g;
    logic        busy;
    logic [15:0] len;   // 0 = length not checked
  } seg_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  logic rand_done = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  seg_t exp_q[$];

  always #5 clk = ~clk;

  tribus_arbiter_if #(.N_REQ(N)) u_if ();
  tribus_arbiter_if #(.N_REQ(N)) u_if2 ();

  tribus_arbiter #(.N_REQ(N), .TURNAROUND(1), .MAX_HOLD(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .arb (u_if.master)
  );

  tribus_arbiter #(.N_REQ(N), .TURNAROUND(2), .MAX_HOLD(8)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .arb (u_if2.master)
  );

  // Driver i puts one-hot (1 << i) on the shared bus.
  wire [3:0] w_bus;
  for (genvar i = 0; i < 4; i++) begin : g_drv
    for (genvar b = 0; b < 4; b++) begin : g_bit
      bufif0 u_drv (w_bus[b], (i == b) ? 1'b1 : 1'b0, u_if2.en_n[i]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic push(input logic [3:0] g, input logic busy, input int len);
    seg_t s;
    s.g = g;
    s.busy = busy;
    s.len = 16'(len);
    exp_q.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Scoreboard monitor for the main DUT.
  initial begin
    logic [4:0] prev_key;
    logic [4:0] key;
    logic [3:0] inv;
    int   run;
    seg_t cur;
    prev_key = '0;
    run = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_key = '0;
        run = 0;
        cur = '0;
      end else begin
        inv = ~u_if.grant;
        check("en_n_inv", {28'b0, u_if.en_n}, {28'b0, inv});
        check("grant_onehot", {31'b0, $countones(u_if.grant) <= 1}, 32'd1);
        key = {u_if.grant, u_if.bus_busy};
        if (key != prev_key) begin
          if (cur.len != 0) check("seg_len", run, {16'b0, cur.len});
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL seg_unexpected: got grant=%b busy=%b, expected no change",
                     u_if.grant, u_if.bus_busy);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            check("seg_grant", {28'b0, u_if.grant}, {28'b0, cur.g});
            check("seg_busy", {31'b0, u_if.bus_busy}, {31'b0, cur.busy});
            if (cur.g != 0) check("seg_owner", {30'b0, u_if.owner}, onehot_idx(cur.g));
          end
          prev_key = key;
          run = 1;
        end else begin
          run++;
        end
      end
    end
  end

  // Contention monitor for the TURNAROUND=2 instance.
  initial begin
    logic [3:0] prev_g;
    logic [3:0] inv;
    int   zero_run;
    bit   had_grant;
    prev_g = '0;
    zero_run = 0;
    had_grant = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst2) begin
        inv = ~u_if2.grant;
        check("c_en_n_inv", {28'b0, u_if2.en_n}, {28'b0, inv});
        check("c_drv_onehot", {31'b0, $countones(~u_if2.en_n) <= 1}, 32'd1);
        if (u_if2.grant != 0) begin
          check("c_bus_value", {28'b0, w_bus}, {28'b0, u_if2.grant});
          if (prev_g == 0 && had_grant) check("c_gap_ge2", {31'b0, zero_run >= 2}, 32'd1);
          if (prev_g != 0 && prev_g != u_if2.grant) begin
            n_checks++;
            n_errors++;
            $display("FAIL c_direct_handover: got %b after %b, expected a dead gap",
                     u_if2.grant, prev_g);
          end
          had_grant = 1'b1;
          zero_run = 0;
        end else begin
          zero_run++;
        end
        prev_g = u_if2.grant;
      end
    end
  end

  // Random stimulus for the contention instance.
  initial begin
    u_if2.req = '0;
    #1 rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) u_if2.req = 4'($urandom);
    end
    rand_done = 1'b1;
  end

  // Directed scenarios on the main instance.
  initial begin
    int guard;
    u_if.req = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", {28'b0, u_if.grant}, 32'h0);
    check("rst_en_n", {28'b0, u_if.en_n}, 32'hF);
    check("rst_owner", {30'b0, u_if.owner}, 32'h0);
    check("rst_busy", {31'b0, u_if.bus_busy}, 32'h0);
    rst = 1'b0;

    // Round robin from reset: 0,1,2,3,0 with 8-cycle tenures, 1-cycle gaps.
    push(4'b0001, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0010, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0100, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b1000, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0001, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0000, 1'b0, 0);
    u_if.req = 4'b1111;
    tick(44);
    u_if.req = 4'b0000;
    tick(4);

    // Single requester: 20-cycle hold with no forced release.
    push(4'b0100, 1'b1, 20); push(4'b0000, 1'b1, 1); push(4'b0000, 1'b0, 0);
    u_if.req = 4'b0100;
    tick(1);
    check("single_en_n", {28'b0, u_if.en_n}, 32'hB);
    check("single_owner", {30'b0, u_if.owner}, 32'd2);
    tick(19);
    u_if.req = 4'b0000;
    tick(4);

    // Asynchronous reset in the middle of a grant held by requester 2.
    push(4'b0100, 1'b1, 0);
    u_if.req = 4'b0100;
    tick(3);
    check("pre_rst_grant", {28'b0, u_if.grant}, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", {28'b0, u_if.grant}, 32'h0);
    check("async_rst_en_n", {28'b0, u_if.en_n}, 32'hF);
    check("async_rst_busy", {31'b0, u_if.bus_busy}, 32'h0);
    check("async_rst_owner", {30'b0, u_if.owner}, 32'h0);
    u_if.req = 4'b1111;
    push(4'b0001, 1'b1, 8); push(4'b0000, 1'b1, 1); push(4'b0000, 1'b0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick(8);
    u_if.req = 4'b0000;
    tick(4);

    // Forced release between requesters 0 and 1.
    do_reset();
    push(4'b0001, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0010, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0001, 1'b1, 8); push(4'b0000, 1'b1, 1);
    push(4'b0000, 1'b0, 0);
    u_if.req = 4'b0011;
    tick(26);
    u_if.req = 4'b0000;
    tick(4);

    // Owner 1 drops req on the same edge requester 3 raises it.
    push(4'b0010, 1'b1, 5); push(4'b0000, 1'b1, 1);
    push(4'b1000, 1'b1, 5); push(4'b0000, 1'b1, 1);
    push(4'b0000, 1'b0, 0);
    u_if.req = 4'b0010;
    tick(5);
    u_if.req = 4'b1000;
    tick(6);
    u_if.req = 4'b0000;
    tick(4);

    check("queue_drained", exp_q.size(), 32'd0);

    guard = 0;
    while (!rand_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    check("random_done", {31'b0, rand_done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
